// File: rtl/uart_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register word offsets,
// STATUS bit positions and the transmit FSM state type.
package uart_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;

  localparam int ST_BUSY      = 0;
  localparam int ST_FULL      = 1;
  localparam int ST_EMPTY     = 2;
  localparam int ST_OVF       = 3;
  localparam int ST_LEVEL_LSB = 8;

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count. A push while full is dropped even if a pop
// happens in the same cycle; a pop while empty is ignored.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (level == (AW+1)'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // NOTE: the storage array has no reset; its contents only matter below level,
  // and the pointers/level carry the reset state.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU stores fill a TX FIFO, the FSM serialises
// bytes LSB-first on tx_o; STATUS/BAUDDIV are read through a registered port.
module uart_tx_mmio
  import uart_pkg::*;
#(
  parameter int FIFO_DEPTH = 8,
  parameter int DIV_W      = 16,
  parameter int DIV_RESET  = 434
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        sel,
  input  logic        wr,
  input  logic        rd,
  input  logic [3:0]  addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        tx_o,
  output logic        irq_o
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  logic [1:0]       word;
  logic             wr_en;
  logic             rd_en;
  logic             push_req;
  logic             fifo_pop;
  logic             fifo_full;
  logic             fifo_empty;
  logic [7:0]       fifo_dout;
  logic [LW-1:0]    fifo_level;
  logic             ovf;
  logic [DIV_W-1:0] bauddiv;
  logic [DIV_W-1:0] div_lat;
  logic [DIV_W-1:0] baud_cnt;
  logic [2:0]       bit_cnt;
  logic [7:0]       shreg;
  logic             bit_end;
  logic [31:0]      status;
  logic [31:0]      rd_mux;
  tx_state_e        state;
  tx_state_e        next_state;
  logic             unused_ok;

  assign word      = addr[3:2];
  assign wr_en     = sel & wr;
  assign rd_en     = sel & rd;
  assign push_req  = wr_en && (word == REG_TXDATA);
  assign unused_ok = ^{addr[1:0], wdata[31:DIV_W]};

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push_req),
    .pop   (fifo_pop),
    .din   (wdata[7:0]),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  // Overflow is sticky; a set in the same cycle as a clear takes priority.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ovf     <= 1'b0;
      bauddiv <= DIV_W'(DIV_RESET);
    end else begin
      if (push_req && fifo_full)
        ovf <= 1'b1;
      else if (wr_en && (word == REG_STATUS) && wdata[ST_OVF])
        ovf <= 1'b0;
      if (wr_en && (word == REG_BAUDDIV))
        bauddiv <= (wdata[DIV_W-1:0] == '0) ? DIV_W'(1) : wdata[DIV_W-1:0];
    end
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    status                          = '0;
    status[ST_BUSY]                 = (state != S_IDLE);
    status[ST_FULL]                 = fifo_full;
    status[ST_EMPTY]                = fifo_empty;
    status[ST_OVF]                  = ovf;
    status[ST_LEVEL_LSB +: LW]      = fifo_level;
  end

  always_comb begin
    rd_mux = '0;
    case (word)
      REG_STATUS:  rd_mux = status;
      REG_BAUDDIV: rd_mux[DIV_W-1:0] = bauddiv;
      default:     rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)      rdata <= '0;
    else if (rd_en) rdata <= rd_mux;
  end

  assign bit_end = (baud_cnt == '0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= next_state;
  end

  // Popping from STOP chains the next frame with no idle gap.
  always_comb begin
    next_state = state;
    fifo_pop   = 1'b0;
    case (state)
      S_IDLE: begin
        if (!fifo_empty) begin
          fifo_pop   = 1'b1;
          next_state = S_START;
        end
      end
      S_START: if (bit_end) next_state = S_DATA;
      S_DATA:  if (bit_end && (bit_cnt == 3'd7)) next_state = S_STOP;
      S_STOP: begin
        if (bit_end) begin
          if (!fifo_empty) begin
            fifo_pop   = 1'b1;
            next_state = S_START;
          end else begin
            next_state = S_IDLE;
          end
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // The divider is latched at pop so BAUDDIV writes only affect the next frame.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      div_lat  <= DIV_W'(1);
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
    end else if (fifo_pop) begin
      div_lat  <= bauddiv;
      baud_cnt <= bauddiv - 1'b1;
      bit_cnt  <= '0;
      shreg    <= fifo_dout;
    end else if (state != S_IDLE) begin
      if (bit_end) begin
        baud_cnt <= div_lat - 1'b1;
        if (state == S_DATA) begin
          shreg   <= shreg >> 1;
          bit_cnt <= bit_cnt + 1'b1;
        end
      end else begin
        baud_cnt <= baud_cnt - 1'b1;
      end
    end
  end

  always_comb begin
    tx_o = 1'b1;
    case (state)
      S_START: tx_o = 1'b0;
      S_DATA:  tx_o = shreg[0];
      default: tx_o = 1'b1;
    endcase
  end

  assign irq_o = fifo_empty && (state == S_IDLE);

endmodule
